// File: rtl/display_scan_controller_if.sv
// Load handshake between a BCD value source and the display scan controller.
// The source holds bcd_in stable while load_valid is high and load_ready is low.
interface display_scan_controller_if;
  logic [11:0] bcd_in;
  logic        load_valid;
  logic        load_ready;

  modport master (
    output bcd_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  bcd_in,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexed 3-digit BCD display scanner with a one-deep load buffer,
// anti-ghost blanking at the start of each slot and optional leading-zero blanking.
module display_scan_controller #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            reset,
  display_scan_controller_if.slave        load_if,
  input  logic                            blank_lz,
  output logic [3:0]                      cur_digit,
  output logic                            enable_pin_1,
  output logic                            enable_pin_2,
  output logic                            enable_pin_3,
  output logic                            frame_done
);

  typedef enum logic [1:0] {
    SLOT_UNITS    = 2'd0,
    SLOT_TENS     = 2'd1,
    SLOT_HUNDREDS = 2'd2
  } slot_e;

  localparam logic [15:0] LAST_T  = 16'(SLOT_CYCLES - 1);
  localparam logic [15:0] BLANK_T = 16'(BLANK_CYCLES);

  slot_e       r_slot;
  logic [15:0] r_t;
  logic [11:0] r_active;
  logic [11:0] r_pending;
  logic        r_pendingFull;
  logic [3:0]  r_curDigit;
  logic [2:0]  r_enables;
  logic        r_frameDone;

  slot_e       w_slotNext;
  logic [15:0] w_tNext;
  logic [11:0] w_activeNext;
  logic [11:0] w_pendingNext;
  logic        w_pendingFullNext;
  logic [3:0]  w_curDigitNext;
  logic [2:0]  w_enablesNext;
  logic        w_frameDoneNext;
  logic        w_lastT;
  logic        w_boundary;
  logic        w_transfer;
  logic [3:0]  w_digitSel;
  logic        w_blanked;
  logic        w_lit;

  // Outputs are computed from the next-cycle state so they can be registered
  // and still line up with the slot/t value they describe.
  always_comb begin
    w_lastT           = (r_t == LAST_T);
    w_boundary        = w_lastT && (r_slot == SLOT_HUNDREDS);
    w_transfer        = load_if.load_valid && !r_pendingFull;
    w_tNext           = w_lastT ? 16'd0 : r_t + 16'd1;
    w_slotNext        = r_slot;
    w_activeNext      = r_active;
    w_pendingNext     = r_pending;
    w_pendingFullNext = r_pendingFull;
    w_digitSel        = 4'hF;
    w_blanked         = 1'b0;
    w_curDigitNext    = 4'hF;
    w_enablesNext     = 3'b111;

    if (w_lastT) begin
      case (r_slot)
        SLOT_UNITS: w_slotNext = SLOT_TENS;
        SLOT_TENS:  w_slotNext = SLOT_HUNDREDS;
        default:    w_slotNext = SLOT_UNITS;
      endcase
    end

    if (w_boundary && r_pendingFull) begin
      w_activeNext      = r_pending;
      w_pendingFullNext = 1'b0;
    end else if (w_transfer) begin
      w_pendingNext     = load_if.bcd_in;
      w_pendingFullNext = 1'b1;
    end

    // Codes 10..15 count as nonzero, so only a literal 0 can be blanked.
    case (w_slotNext)
      SLOT_UNITS: begin
        w_digitSel = w_activeNext[3:0];
        w_blanked  = 1'b0;
      end
      SLOT_TENS: begin
        w_digitSel = w_activeNext[7:4];
        w_blanked  = blank_lz && (w_activeNext[11:8] == 4'd0) && (w_activeNext[7:4] == 4'd0);
      end
      default: begin
        w_digitSel = w_activeNext[11:8];
        w_blanked  = blank_lz && (w_activeNext[11:8] == 4'd0);
      end
    endcase

    w_lit = (w_tNext >= BLANK_T) && !w_blanked;
    if (w_lit) begin
      w_curDigitNext = w_digitSel;
      case (w_slotNext)
        SLOT_UNITS: w_enablesNext = 3'b110;
        SLOT_TENS:  w_enablesNext = 3'b101;
        default:    w_enablesNext = 3'b011;
      endcase
    end

    w_frameDoneNext = (w_slotNext == SLOT_HUNDREDS) && (w_tNext == LAST_T);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot        <= SLOT_UNITS;
      r_t           <= 16'd0;
      r_active      <= 12'h000;
      r_pending     <= 12'h000;
      r_pendingFull <= 1'b0;
      r_curDigit    <= 4'hF;
      r_enables     <= 3'b111;
      r_frameDone   <= 1'b0;
    end else begin
      r_slot        <= w_slotNext;
      r_t           <= w_tNext;
      r_active      <= w_activeNext;
      r_pending     <= w_pendingNext;
      r_pendingFull <= w_pendingFullNext;
      r_curDigit    <= w_curDigitNext;
      r_enables     <= w_enablesNext;
      r_frameDone   <= w_frameDoneNext;
    end
  end

  assign load_if.load_ready = ~r_pendingFull;
  assign cur_digit          = r_curDigit;
  assign enable_pin_1       = r_enables[2];
  assign enable_pin_2       = r_enables[1];
  assign enable_pin_3       = r_enables[0];
  assign frame_done         = r_frameDone;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller with SLOT_CYCLES=8, BLANK_CYCLES=2.
// A cycle-count model of the display is compared against the DUT every cycle.
module tb_display_scan_controller;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 3 * SLOT;

  logic       clk = 1'b0;
  logic       reset;
  logic       blank_lz;
  logic [3:0] cur_digit;
  logic       en1, en2, en3;
  logic       frame_done;

  int vectors    = 0;
  int miscompares = 0;

  display_scan_controller_if ifc ();

  display_scan_controller #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_if      (ifc.slave),
    .blank_lz     (blank_lz),
    .cur_digit    (cur_digit),
    .enable_pin_1 (en1),
    .enable_pin_2 (en2),
    .enable_pin_3 (en3),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // Model state: mP counts clocks since reset release, so slot and t follow from it.
  int          mP      = 0;
  logic [11:0] mActive = 12'h000;
  logic [11:0] mPending = 12'h000;
  logic        mFull   = 1'b0;
  logic        mBlz    = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mP      = 0;
      mActive = 12'h000;
      mFull   = 1'b0;
      mBlz    = 1'b0;
    end else begin
      if ((mP % FRAME) == FRAME - 1 && mFull) begin
        mActive = mPending;
        mFull   = 1'b0;
      end else if (ifc.load_valid && !mFull) begin
        mPending = ifc.bcd_in;
        mFull    = 1'b1;
      end
      mBlz = blank_lz;
      mP   = mP + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at p=%0d: got %h, expected %h", name, mP, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    int slot, t;
    logic blanked, lit;
    logic [3:0] expDigit;
    logic [2:0] expEn;
    slot    = (mP / SLOT) % 3;
    t       = mP % SLOT;
    blanked = mBlz && ((slot == 2 && mActive[11:8] == 4'd0) ||
                       (slot == 1 && mActive[11:8] == 4'd0 && mActive[7:4] == 4'd0));
    lit      = (t >= BLANK) && !blanked;
    expDigit = lit ? mActive[slot*4 +: 4] : 4'hF;
    expEn    = lit ? (3'b111 & ~(3'b001 << slot)) : 3'b111;
    checkOutput("cur_digit", {12'd0, cur_digit}, {12'd0, expDigit});
    checkOutput("enables", {13'd0, en1, en2, en3}, {13'd0, expEn});
    checkOutput("frame_done", {15'd0, frame_done}, {15'd0, (reset && (mP % FRAME) == FRAME - 1)});
    checkOutput("load_ready", {15'd0, ifc.load_ready}, {15'd0, !mFull});
  end

  task automatic waitCycle(input int target);
    int n = 0;
    while (mP < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (mP != target) checkOutput("waitCycle", 16'(mP), 16'(target));
  endtask

  task automatic applyStimulus(input logic [11:0] v);
    int n = 0;
    ifc.bcd_in     = v;
    ifc.load_valid = 1'b1;
    while (!ifc.load_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.load_ready) checkOutput("load_timeout", 16'd0, 16'd1);
    @(negedge clk);
    ifc.load_valid = 1'b0;
  endtask

  task automatic checkLit(input string name, input logic [3:0] digit, input logic [2:0] en);
    checkOutput({name, "_digit"}, {12'd0, cur_digit}, {12'd0, digit});
    checkOutput({name, "_en"}, {13'd0, en1, en2, en3}, {13'd0, en});
  endtask

  initial begin
    reset          = 1'b1;
    blank_lz       = 1'b0;
    ifc.bcd_in     = 12'h000;
    ifc.load_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkLit("reset", 4'hF, 3'b111);
    checkOutput("reset_fd", {15'd0, frame_done}, 16'd0);
    checkOutput("reset_ready", {15'd0, ifc.load_ready}, 16'd1);
    reset = 1'b1;

    // Power-up value 000, no blanking.
    waitCycle(2);  checkLit("a_units", 4'h0, 3'b110);
    waitCycle(12); checkLit("a_tens", 4'h0, 3'b101);
    waitCycle(23); checkLit("a_hund", 4'h0, 3'b011);
    checkOutput("a_fd23", {15'd0, frame_done}, 16'd1);
    waitCycle(24); checkOutput("a_fd24", {15'd0, frame_done}, 16'd0);

    // 007 with leading-zero blanking: only units lit.
    waitCycle(30);
    blank_lz = 1'b1;
    applyStimulus(12'h007);
    waitCycle(50); checkLit("b_units", 4'h7, 3'b110);
    waitCycle(59); checkLit("b_tens", 4'hF, 3'b111);
    waitCycle(69); checkLit("b_hund", 4'hF, 3'b111);
    waitCycle(71); checkOutput("b_fd71", {15'd0, frame_done}, 16'd1);

    // 305: tens shows 0 because hundreds is nonzero.
    waitCycle(75);
    applyStimulus(12'h305);
    waitCycle(98);  checkLit("c_units", 4'h5, 3'b110);
    waitCycle(106); checkLit("c_tens", 4'h0, 3'b101);
    waitCycle(114); checkLit("c_hund", 4'h3, 3'b011);

    // Back-to-back loads: second waits for the buffer to drain at a boundary.
    waitCycle(122);
    applyStimulus(12'h123);
    checkOutput("d_ready123", {15'd0, ifc.load_ready}, 16'd0);
    applyStimulus(12'h456);
    waitCycle(146); checkLit("d_123", 4'h3, 3'b110);
    waitCycle(170); checkLit("d_456", 4'h6, 3'b110);

    // Load on the frame_done cycle lands one frame later.
    waitCycle(191);
    applyStimulus(12'h999);
    waitCycle(194); checkLit("e_still456", 4'h6, 3'b110);
    waitCycle(218); checkLit("e_999", 4'h9, 3'b110);

    // Asynchronous reset mid-slot 1 with a pending value.
    waitCycle(220);
    applyStimulus(12'h321);
    waitCycle(227);
    #2 reset = 1'b0;
    #1;
    checkLit("f_async", 4'hF, 3'b111);
    checkOutput("f_ready", {15'd0, ifc.load_ready}, 16'd1);
    checkOutput("f_fd", {15'd0, frame_done}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    waitCycle(2);  checkLit("f_units", 4'h0, 3'b110);
    waitCycle(10); checkLit("f_tens", 4'hF, 3'b111);
    waitCycle(26); checkLit("f_discard", 4'h0, 3'b110);
    waitCycle(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
